// File: rtl/ahb_lite_interconnect.sv
// Single-master AHB-Lite interconnect: base/mask slave decode, default ERROR slave
// for unmapped addresses, stall watchdog, and last-error address/count logging.
module ahb_lite_interconnect #(
    parameter int unsigned                NUM_SLAVES     = 3,
    parameter logic [32*NUM_SLAVES-1:0]   SLV_BASE       = {32'h1F80_0000, 32'h1FC0_0000, 32'h0000_0000},
    parameter logic [32*NUM_SLAVES-1:0]   SLV_MASK       = {32'hFFFF_0000, 32'hFFF0_0000, 32'hFFF0_0000},
    parameter int unsigned                TIMEOUT_CYCLES = 64
) (
    input  logic                         HCLK,
    input  logic                         HRESETn,
    input  logic [31:0]                  HADDR,
    input  logic [1:0]                   HTRANS,
    input  logic                         HWRITE,
    output logic [31:0]                  HRDATA,
    output logic                         HREADY,
    output logic                         HRESP,
    output logic [NUM_SLAVES-1:0]        HSEL_S,
    input  logic [32*NUM_SLAVES-1:0]     HRDATA_S,
    input  logic [NUM_SLAVES-1:0]        HREADYOUT_S,
    input  logic [NUM_SLAVES-1:0]        HRESP_S,
    output logic [31:0]                  ERR_ADDR,
    output logic [7:0]                   ERR_CNT
);

    localparam int unsigned WCW = (TIMEOUT_CYCLES > 32'd0) ? $clog2(TIMEOUT_CYCLES + 32'd1) : 1;
    localparam logic [WCW-1:0] WLIM = WCW'((TIMEOUT_CYCLES > 32'd0) ? (TIMEOUT_CYCLES - 32'd1) : 32'd0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SLAVE = 2'd1,
        ST_ERR1  = 2'd2,
        ST_ERR2  = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_SLAVES-1:0]   sel_q, sel_d;   // one-hot; all-zero means no slave
    logic [31:0]             addr_q, addr_d;
    logic [WCW-1:0]          wcnt_q, wcnt_d;
    logic [31:0]             err_addr_q, err_addr_d;
    logic [7:0]              err_cnt_q, err_cnt_d;

    logic [NUM_SLAVES-1:0]   hit_s;
    logic [NUM_SLAVES-1:0]   win_s;
    logic [NUM_SLAVES-1:0]   hsel_s;
    logic [31:0]             rdata_sel_s;
    logic                    ready_sel_s;
    logic                    resp_sel_s;
    logic                    hready_s;
    logic                    hresp_s;
    logic [31:0]             hrdata_s;
    logic                    unused_s;

    // Address decode; lowest-index hit wins by isolating the lowest set bit.
    always_comb begin
        hit_s = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            hit_s[i] = ((HADDR & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]);
        end
        win_s  = hit_s & (~hit_s + NUM_SLAVES'(1));
        hsel_s = win_s & {NUM_SLAVES{HTRANS[1]}};
    end

    // Response mux of the slave owning the current data phase.
    always_comb begin
        rdata_sel_s = 32'h0000_0000;
        ready_sel_s = 1'b0;
        resp_sel_s  = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            rdata_sel_s = rdata_sel_s | (HRDATA_S[32*i +: 32] & {32{sel_q[i]}});
            ready_sel_s = ready_sel_s | (HREADYOUT_S[i] & sel_q[i]);
            resp_sel_s  = resp_sel_s  | (HRESP_S[i] & sel_q[i]);
        end
    end

    // Master-side response, next-state, watchdog and error logging.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        wcnt_d     = wcnt_q;
        err_addr_d = err_addr_q;
        err_cnt_d  = err_cnt_q;
        hready_s   = 1'b1;
        hresp_s    = 1'b0;
        hrdata_s   = 32'h0000_0000;

        case (state_q)
            ST_IDLE: begin
                hready_s = 1'b1;
                hresp_s  = 1'b0;
            end
            ST_SLAVE: begin
                hready_s = ready_sel_s;
                hresp_s  = resp_sel_s;
                hrdata_s = rdata_sel_s;
            end
            ST_ERR1: begin
                hready_s = 1'b0;
                hresp_s  = 1'b1;
            end
            ST_ERR2: begin
                hready_s = 1'b1;
                hresp_s  = 1'b1;
            end
            default: begin
                hready_s = 1'b1;
                hresp_s  = 1'b0;
            end
        endcase

        if (hready_s) begin
            sel_d  = hsel_s;
            addr_d = HADDR;
            wcnt_d = '0;
            if (!HTRANS[1]) begin
                state_d = ST_IDLE;
            end else if (|win_s) begin
                state_d = ST_SLAVE;
            end else begin
                state_d = ST_ERR1;
            end
        end else if (state_q == ST_ERR1) begin
            state_d = ST_ERR2;
        end else if ((TIMEOUT_CYCLES != 32'd0) && (wcnt_q == WLIM)) begin
            // Abandon the stalled slave; its outputs are no longer muxed.
            state_d = ST_ERR1;
            sel_d   = '0;
        end else begin
            state_d = ST_SLAVE;
            wcnt_d  = wcnt_q + WCW'(1);
        end

        if (hready_s && hresp_s) begin
            err_addr_d = addr_q;
            err_cnt_d  = (err_cnt_q == 8'hFF) ? 8'hFF : (err_cnt_q + 8'd1);
        end else begin
            err_addr_d = err_addr_q;
            err_cnt_d  = err_cnt_q;
        end
    end

    // State and logging registers.
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= ST_IDLE;
            sel_q      <= '0;
            addr_q     <= 32'h0000_0000;
            wcnt_q     <= '0;
            err_addr_q <= 32'h0000_0000;
            err_cnt_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            wcnt_q     <= wcnt_d;
            err_addr_q <= err_addr_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    assign HSEL_S   = hsel_s;
    assign HREADY   = hready_s;
    assign HRESP    = hresp_s;
    assign HRDATA   = hrdata_s;
    assign ERR_ADDR = err_addr_q;
    assign ERR_CNT  = err_cnt_q;
    assign unused_s = HWRITE ^ HTRANS[0];

endmodule

// File: tb/tb_ahb_lite_interconnect.sv
// Directed bench for ahb_lite_interconnect with a short watchdog (TIMEOUT_CYCLES = 4).
module tb_ahb_lite_interconnect;

    logic        HCLK;
    logic        HRESETn;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;
    logic [2:0]  HSEL_S;
    logic [95:0] HRDATA_S;
    logic [2:0]  HREADYOUT_S;
    logic [2:0]  HRESP_S;
    logic [31:0] ERR_ADDR;
    logic [7:0]  ERR_CNT;

    int checks = 0;
    int errors = 0;

    ahb_lite_interconnect #(
        .NUM_SLAVES     (3),
        .SLV_BASE       ({32'h1F80_0000, 32'h1FC0_0000, 32'h0000_0000}),
        .SLV_MASK       ({32'hFFFF_0000, 32'hFFF0_0000, 32'hFFF0_0000}),
        .TIMEOUT_CYCLES (4)
    ) dut (
        .HCLK        (HCLK),
        .HRESETn     (HRESETn),
        .HADDR       (HADDR),
        .HTRANS      (HTRANS),
        .HWRITE      (HWRITE),
        .HRDATA      (HRDATA),
        .HREADY      (HREADY),
        .HRESP       (HRESP),
        .HSEL_S      (HSEL_S),
        .HRDATA_S    (HRDATA_S),
        .HREADYOUT_S (HREADYOUT_S),
        .HRESP_S     (HRESP_S),
        .ERR_ADDR    (ERR_ADDR),
        .ERR_CNT     (ERR_CNT)
    );

    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    task automatic test_reset;
        HRESETn = 1'b0;
        HADDR = 32'h1FC0_0000; HTRANS = 2'b10; HWRITE = 1'b0;
        HRDATA_S = 96'h0; HREADYOUT_S = 3'b111; HRESP_S = 3'b000;
        #1;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rst_hready got %0b exp 1", HREADY); end
        checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rst_hresp got %0b exp 0", HRESP); end
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rst_hrdata got %h exp 0", HRDATA); end
        checks++; if (ERR_CNT !== 8'h00) begin errors++; $display("FAIL rst_errcnt got %0d exp 0", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'h0) begin errors++; $display("FAIL rst_erraddr got %h exp 0", ERR_ADDR); end
        checks++; if (HSEL_S !== 3'b010) begin errors++; $display("FAIL rst_hsel got %b exp 010", HSEL_S); end
        @(negedge HCLK);
        HRESETn = 1'b1; HTRANS = 2'b00;
    endtask

    task automatic test_read;
        @(negedge HCLK);
        HADDR = 32'h1FC0_0010; HTRANS = 2'b10; HWRITE = 1'b0; HRDATA_S[63:32] = 32'hDEAD_BEEF;
        #1;
        checks++; if (HSEL_S !== 3'b010) begin errors++; $display("FAIL rd_hsel got %b exp 010", HSEL_S); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rd_addr_hready got %0b exp 1", HREADY); end
        @(negedge HCLK);
        HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== 32'hDEAD_BEEF) begin errors++; $display("FAIL rd_data got %h exp deadbeef", HRDATA); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rd_hready got %0b exp 1", HREADY); end
        checks++; if (HRESP !== 1'b0) begin errors++; $display("FAIL rd_hresp got %0b exp 0", HRESP); end
        @(negedge HCLK);
        #1;
        checks++; if (HRDATA !== 32'h0) begin errors++; $display("FAIL rd_idle_data got %h exp 0", HRDATA); end
    endtask

    task automatic test_back_to_back;
        @(negedge HCLK);
        HADDR = 32'h1F80_0004; HTRANS = 2'b10; HWRITE = 1'b1;
        #1;
        checks++; if (HSEL_S !== 3'b100) begin errors++; $display("FAIL b2b_wr_hsel got %b exp 100", HSEL_S); end
        for (int k = 0; k < 3; k++) begin
            @(negedge HCLK);
            if (k == 0) begin
                HREADYOUT_S = 3'b011; HADDR = 32'h0000_0000; HTRANS = 2'b10; HWRITE = 1'b0;
                HRDATA_S[31:0] = 32'h1234_5678;
            end
            #1;
            checks++; if (HREADY !== 1'b0) begin errors++; $display("FAIL b2b_wait%0d got %0b exp 0", k, HREADY); end
        end
        @(negedge HCLK);
        HREADYOUT_S = 3'b111;
        #1;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL b2b_wr_done got %0b exp 1", HREADY); end
        checks++; if (HSEL_S !== 3'b001) begin errors++; $display("FAIL b2b_rd_hsel got %b exp 001", HSEL_S); end
        @(negedge HCLK);
        HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== 32'h1234_5678) begin errors++; $display("FAIL b2b_rd_data got %h exp 12345678", HRDATA); end
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL b2b_rd_hready got %0b exp 1", HREADY); end
    endtask

    task automatic test_unmapped;
        @(negedge HCLK);
        HADDR = 32'h4000_0000; HTRANS = 2'b10;
        #1;
        checks++; if (HSEL_S !== 3'b000) begin errors++; $display("FAIL um_hsel got %b exp 000", HSEL_S); end
        @(negedge HCLK);
        HTRANS = 2'b00;
        #1;
        checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL um_err1 got rdy=%0b rsp=%0b exp 0/1", HREADY, HRESP); end
        @(negedge HCLK);
        #1;
        checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL um_err2 got rdy=%0b rsp=%0b exp 1/1", HREADY, HRESP); end
        @(negedge HCLK);
        #1;
        checks++; if (ERR_ADDR !== 32'h4000_0000) begin errors++; $display("FAIL um_erraddr got %h exp 40000000", ERR_ADDR); end
        checks++; if (ERR_CNT !== 8'd1) begin errors++; $display("FAIL um_errcnt got %0d exp 1", ERR_CNT); end
        checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL um_after got rdy=%0b rsp=%0b exp 1/0", HREADY, HRESP); end
    endtask

    task automatic test_timeout;
        @(negedge HCLK);
        HADDR = 32'h0000_0100; HTRANS = 2'b10; HREADYOUT_S = 3'b110;
        for (int k = 0; k < 4; k++) begin
            @(negedge HCLK);
            if (k == 0) begin
                HADDR = 32'h1FC0_0020; HTRANS = 2'b10; HRDATA_S[63:32] = 32'hCAFE_F00D;
            end
            #1;
            checks++; if (HREADY !== 1'b0 || HRESP !== 1'b0) begin errors++; $display("FAIL to_wait%0d got rdy=%0b rsp=%0b exp 0/0", k, HREADY, HRESP); end
        end
        @(negedge HCLK);
        #1;
        checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL to_err1 got rdy=%0b rsp=%0b exp 0/1", HREADY, HRESP); end
        @(negedge HCLK);
        #1;
        checks++; if (HREADY !== 1'b1 || HRESP !== 1'b1) begin errors++; $display("FAIL to_err2 got rdy=%0b rsp=%0b exp 1/1", HREADY, HRESP); end
        @(negedge HCLK);
        HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== 32'hCAFE_F00D || HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL to_next got d=%h rdy=%0b rsp=%0b exp cafef00d/1/0", HRDATA, HREADY, HRESP); end
        checks++; if (ERR_CNT !== 8'd2) begin errors++; $display("FAIL to_errcnt got %0d exp 2", ERR_CNT); end
        checks++; if (ERR_ADDR !== 32'h0000_0100) begin errors++; $display("FAIL to_erraddr got %h exp 00000100", ERR_ADDR); end
        HREADYOUT_S = 3'b111;
    endtask

    task automatic test_idle_unmapped;
        @(negedge HCLK);
        HADDR = 32'h4000_0000; HTRANS = 2'b00;
        #1;
        checks++; if (HSEL_S !== 3'b000) begin errors++; $display("FAIL iu_hsel got %b exp 000", HSEL_S); end
        @(negedge HCLK);
        #1;
        checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL iu_resp got rdy=%0b rsp=%0b exp 1/0", HREADY, HRESP); end
        checks++; if (ERR_CNT !== 8'd2) begin errors++; $display("FAIL iu_errcnt got %0d exp 2", ERR_CNT); end
    endtask

    task automatic test_saturate;
        @(negedge HCLK);
        HADDR = 32'h4000_0000; HTRANS = 2'b10;
        repeat (21) @(negedge HCLK);
        #1;
        checks++; if (ERR_CNT !== 8'd12) begin errors++; $display("FAIL sat_mid got %0d exp 12", ERR_CNT); end
        repeat (580) @(negedge HCLK);
        HTRANS = 2'b00;
        repeat (3) @(negedge HCLK);
        #1;
        checks++; if (ERR_CNT !== 8'd255) begin errors++; $display("FAIL sat_errcnt got %0d exp 255", ERR_CNT); end
        checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL sat_after got rdy=%0b rsp=%0b exp 1/0", HREADY, HRESP); end
    endtask

    task automatic test_reset_mid_err;
        @(negedge HCLK);
        HADDR = 32'h4000_0000; HTRANS = 2'b10;
        @(negedge HCLK);
        HTRANS = 2'b00;
        #1;
        checks++; if (HREADY !== 1'b0 || HRESP !== 1'b1) begin errors++; $display("FAIL rm_err1 got rdy=%0b rsp=%0b exp 0/1", HREADY, HRESP); end
        #1;
        HRESETn = 1'b0; HADDR = 32'h1FC0_0000; HTRANS = 2'b10;
        #1;
        checks++; if (HREADY !== 1'b1 || HRESP !== 1'b0 || HRDATA !== 32'h0) begin errors++; $display("FAIL rm_outs got rdy=%0b rsp=%0b d=%h exp 1/0/0", HREADY, HRESP, HRDATA); end
        checks++; if (ERR_CNT !== 8'd0 || ERR_ADDR !== 32'h0) begin errors++; $display("FAIL rm_log got cnt=%0d addr=%h exp 0/0", ERR_CNT, ERR_ADDR); end
        checks++; if (HSEL_S !== 3'b010) begin errors++; $display("FAIL rm_hsel got %b exp 010", HSEL_S); end
        @(negedge HCLK);
        HRESETn = 1'b1; HADDR = 32'h1FC0_0040; HTRANS = 2'b10; HRDATA_S[63:32] = 32'h55AA_55AA;
        #1;
        checks++; if (HREADY !== 1'b1) begin errors++; $display("FAIL rm_addr_hready got %0b exp 1", HREADY); end
        @(negedge HCLK);
        HTRANS = 2'b00;
        #1;
        checks++; if (HRDATA !== 32'h55AA_55AA || HREADY !== 1'b1 || HRESP !== 1'b0) begin errors++; $display("FAIL rm_read got d=%h rdy=%0b rsp=%0b exp 55aa55aa/1/0", HRDATA, HREADY, HRESP); end
    endtask

    initial begin
        test_reset();
        test_read();
        test_back_to_back();
        test_unmapped();
        test_timeout();
        test_idle_unmapped();
        test_saturate();
        test_reset_mid_err();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
